// File: rtl/inst_fetch_unit.sv
// Instruction queue and issue sequencer feeding the control unit decoder.
// Host pushes instructions into a circular FIFO. After a start pulse the
// sequencer issues one instruction per cycle. It inserts IDLE bubbles after
// any matrix-multiply-class opcode so the MMU is never re-issued while busy.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; instruction bus held at IDLE (zero)
// S_ISSUE | pop head and issue each cycle; empty queue ends the run
// S_STALL | MMU busy; emit IDLE bubbles until the stall counter hits 0
module inst_fetch_unit #(
  parameter int INST_BITS      = 140,
  parameter int OPCODE_BITS    = 4,
  parameter int DEPTH          = 16,
  parameter int MM_BUSY_CYCLES = 16,
  parameter logic [OPCODE_BITS-1:0] MAT_MUL_OPCODE = 4'h3,
  parameter logic [OPCODE_BITS-1:0] MM_LOAD_OPCODE = 4'h4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [INST_BITS-1:0]     inst_in,
  input  logic                     inst_valid,
  output logic                     inst_ready,
  input  logic                     start,
  output logic [INST_BITS-1:0]     instruction,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int SCW = (MM_BUSY_CYCLES > 2) ? $clog2(MM_BUSY_CYCLES) : 1;
  // A single-cycle MMU op needs no bubbles, so the stall path is disabled.
  localparam bit STALL_EN = (MM_BUSY_CYCLES > 1);
  localparam logic [SCW-1:0] STALL_LOAD =
    SCW'((MM_BUSY_CYCLES > 1) ? (MM_BUSY_CYCLES - 2) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t                 state;
  logic [INST_BITS-1:0]   mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [SCW-1:0]         stall_cnt;

  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic [INST_BITS-1:0]   head;
  logic [OPCODE_BITS-1:0] head_op;
  logic                   head_is_mm;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign inst_ready = !full;
  assign busy       = (state != S_IDLE);
  assign push       = inst_valid && !full;
  assign pop        = (state == S_ISSUE) && !empty;
  assign head       = mem[rd_ptr];
  assign head_op    = head[INST_BITS-1 -: OPCODE_BITS];
  assign head_is_mm = (head_op == MAT_MUL_OPCODE) || (head_op == MM_LOAD_OPCODE);

  // FIFO storage; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= inst_in;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue sequencer with registered instruction and done outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      stall_cnt   <= '0;
      instruction <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          instruction <= '0;
          if (start) state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!empty) begin
            instruction <= head;
            if (head_is_mm && STALL_EN) begin
              stall_cnt <= STALL_LOAD;
              state     <= S_STALL;
            end
          end else begin
            instruction <= '0;
            done        <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_STALL: begin
          instruction <= '0;
          if (stall_cnt == '0) begin
            state <= S_ISSUE;
          end else begin
            stall_cnt <= stall_cnt - 1'b1;
          end
        end
        default: begin
          instruction <= '0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: stimulus queues expected issues
// (value, done flag, cycle gap to the previous output); a monitor pops and
// compares whenever the DUT presents a non-IDLE instruction or done.
module tb_inst_fetch_unit;

  localparam int IB = 140;

  typedef struct {
    logic [IB-1:0] inst;
    logic          dn;
    int            gap;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [IB-1:0] inst_in;
  logic          inst_valid;
  logic          inst_ready;
  logic          start;
  logic [IB-1:0] instruction;
  logic          busy;
  logic          done;
  logic [4:0]    count;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   gap_cnt = 0;

  inst_fetch_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .inst_in     (inst_in),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .start       (start),
    .instruction (instruction),
    .busy        (busy),
    .done        (done),
    .count       (count)
  );

  always #5 clk = ~clk;

  function automatic logic [IB-1:0] mk(input logic [3:0] op, input int tag);
    return {op, 8'hA5, 128'(tag)};
  endfunction

  task automatic chk(input string nm, input logic [IB-1:0] act, input logic [IB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input logic [IB-1:0] v, input logic dn, input int gap);
    exp_t e;
    e.inst = v;
    e.dn   = dn;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  // All tasks below start and end 1 time unit after a rising edge.
  task automatic push(input logic [IB-1:0] v);
    inst_in    = v;
    inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_busy, output int lat);
    int bc;
    bit seen;
    bc   = 0;
    seen = 0;
    lat  = 0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) bc++;
      lat++;
      @(posedge clk); #1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no done within 300 cycles, required done", nm);
    end else if (exp_busy >= 0) begin
      chk({nm, "_busy_cycles"}, IB'(bc), IB'(exp_busy));
    end
  endtask

  // Monitor: pop and compare each presented output, including spacing.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      gap_cnt = 0;
    end else begin
      gap_cnt++;
      if (instruction != '0 || done) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got inst=%0h done=%0b, required no output",
                   instruction, done);
        end else begin
          e = sb.pop_front();
          if (instruction !== e.inst || done !== e.dn || (e.gap >= 0 && gap_cnt != e.gap)) begin
            n_err++;
            $display("FAIL issue: got inst=%0h done=%0b gap=%0d, required inst=%0h done=%0b gap=%0d",
                     instruction, done, gap_cnt, e.inst, e.dn, e.gap);
          end
        end
        gap_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int dn_cnt;
    reset_n    = 1'b0;
    inst_in    = '0;
    inst_valid = 1'b0;
    start      = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_instruction", instruction, '0);
    chk("rst_done", IB'(done), '0);
    chk("rst_busy", IB'(busy), '0);
    chk("rst_ready", IB'(inst_ready), IB'(1));
    chk("rst_count", IB'(count), '0);

    // Three plain instructions: back-to-back issue then done
    expect_out(mk(4'h1, 1), 1'b0, -1);
    expect_out(mk(4'h2, 2), 1'b0, 1);
    expect_out(mk(4'h5, 3), 1'b0, 1);
    expect_out('0, 1'b1, 1);
    push(mk(4'h1, 1));
    push(mk(4'h2, 2));
    push(mk(4'h5, 3));
    chk("t1_count", IB'(count), IB'(3));
    pulse_start();
    wait_done("t1", 4, lat);

    // Mat-mul opcode 3: 15 bubbles before the next issue
    expect_out(mk(4'h3, 10), 1'b0, -1);
    expect_out(mk(4'h1, 11), 1'b0, 16);
    expect_out('0, 1'b1, 1);
    push(mk(4'h3, 10));
    push(mk(4'h1, 11));
    pulse_start();
    wait_done("t2_mm", 18, lat);

    // Mat-mul with load, opcode 4: same spacing
    expect_out(mk(4'h4, 20), 1'b0, -1);
    expect_out(mk(4'h1, 21), 1'b0, 16);
    expect_out('0, 1'b1, 1);
    push(mk(4'h4, 20));
    push(mk(4'h1, 21));
    pulse_start();
    wait_done("t2_ld", 18, lat);

    // Fill to full, refuse a 17th push, drain in order
    for (int i = 0; i < 16; i++) begin
      expect_out(mk(4'h6, 200 + i), 1'b0, (i == 0) ? -1 : 1);
      push(mk(4'h6, 200 + i));
    end
    chk("t3_count_full", IB'(count), IB'(16));
    chk("t3_ready_full", IB'(inst_ready), '0);
    push(mk(4'h6, 999));
    chk("t3_count_after_17th", IB'(count), IB'(16));
    expect_out('0, 1'b1, 1);
    pulse_start();
    wait_done("t3", 17, lat);

    // Full queue, start, stream pushes every cycle across pointer wrap
    for (int i = 0; i < 16; i++) begin
      expect_out(mk(4'h7, 300 + i), 1'b0, (i == 0) ? -1 : 1);
      push(mk(4'h7, 300 + i));
    end
    for (int c = 0; c < 30; c++) begin
      inst_valid = 1'b1;
      inst_in    = mk(4'h7, 400 + c);
      start      = (c == 0);
      if (inst_ready) expect_out(inst_in, 1'b0, 1);
      if (c >= 3) chk("t4_count_steady", IB'(count), IB'(15));
      @(posedge clk); #1;
    end
    inst_valid = 1'b0;
    start      = 1'b0;
    expect_out('0, 1'b1, 1);
    wait_done("t4", -1, lat);

    // Reset during stall: outputs clear at once, run aborted
    expect_out(mk(4'h4, 50), 1'b0, -1);
    push(mk(4'h4, 50));
    push(mk(4'h1, 51));
    pulse_start();
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("t5_rst_instruction", instruction, '0);
    chk("t5_rst_count", IB'(count), '0);
    chk("t5_rst_busy", IB'(busy), '0);
    chk("t5_rst_done", IB'(done), '0);
    chk("t5_mm_seen", IB'(sb.size()), '0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_idle_busy", IB'(busy), '0);
    expect_out('0, 1'b1, -1);
    pulse_start();
    wait_done("t5_empty", 1, lat);
    chk("t5_empty_latency", IB'(lat), IB'(1));

    // Second start during a run is ignored: one done only
    for (int i = 0; i < 4; i++) begin
      expect_out(mk(4'h2, 60 + i), 1'b0, (i == 0) ? -1 : 1);
      push(mk(4'h2, 60 + i));
    end
    expect_out('0, 1'b1, 1);
    pulse_start();
    @(posedge clk); #1;
    pulse_start();
    dn_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dn_cnt++;
      @(posedge clk); #1;
    end
    chk("t6_done_pulses", IB'(dn_cnt), IB'(1));
    chk("t6_busy_after", IB'(busy), '0);

    chk("sb_drained", IB'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
